mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the RV M extension.
// One request in flight; a multi-cycle shift-add / restoring-division
// datapath with sign handling done on absolute values.
module mul_div_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;      // multiplicand / divisor
    logic [XLEN-1:0]   acc_q, acc_d;  // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;    // multiplier -> product low half / dividend -> quotient
    logic              neg_q, neg_d;  // product / quotient sign
    logic              rneg_q, rneg_d;// remainder sign
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Request decode and absolute-value operands.
    logic            is_div, s1_signed, s2_signed, s1_neg, s2_neg;
    logic [XLEN-1:0] abs1, abs2;

    // One datapath iteration, shared between multiply and divide.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_r, div_diff;
    logic [XLEN-1:0] iter_acc, iter_lo;

    // Final sign correction and result selection.
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign rd_out    = rd_q;

    // Decode signedness from op and form operand magnitudes.
    always_comb begin
        is_div    = op[2];
        s1_signed = is_div ? !op[0] : (op[1:0] != 2'b11);
        s2_signed = is_div ? !op[0] : !op[1];
        s1_neg    = s1_signed & src1[XLEN-1];
        s2_neg    = s2_signed & src2[XLEN-1];
        abs1      = s1_neg ? -src1 : src1;
        abs2      = s2_neg ? -src2 : src2;
    end

    // Single shift-add or restoring-division step, plus final result.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        div_r    = {acc_q, lo_q[XLEN-1]};
        div_diff = div_r - {1'b0, a_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                iter_acc = div_diff[XLEN-1:0];
                iter_lo  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                iter_acc = div_r[XLEN-1:0];
                iter_lo  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            iter_acc = mul_sum[XLEN:1];
            iter_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod     = {iter_acc, iter_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -iter_lo : iter_lo;
        rem_fix  = rneg_q ? -iter_acc : iter_acc;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: accept, iterate, hold result until handshake.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    rd_d   = rd_in;
                    cnt_d  = '0;
                    neg_d  = s1_neg ^ s2_neg;
                    rneg_d = s1_neg;
                    acc_d  = '0;
                    if (is_div && (src2 == '0)) begin
                        result_d = op[1] ? src1 : '1;
                        state_d  = S_DONE;
                    end else if (is_div && !op[0] && (src1 == XMIN) && (src2 == '1)) begin
                        result_d = op[1] ? '0 : XMIN;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = is_div ? abs2 : abs1;
                        lo_d    = is_div ? abs1 : abs2;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d = iter_acc;
                lo_d  = iter_lo;
                if (cnt_q == CNT_LAST) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Control and visible outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // Datapath registers; only meaningful after an acceptance.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        a_q    <= a_d;
        acc_q  <= acc_d;
        lo_q   <= lo_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        cnt_q  <= cnt_d;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (XLEN=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mul_div_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic [RD_W-1:0] rd_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;
    logic            busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mul_div_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RD_W-1:0] r);
        int unsigned guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        op = o; src1 = a; src2 = b; rd_in = r; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        src1 = '0; src2 = '0; rd_in = '0; op = '0;
    endtask

    // Edges from acceptance until out_valid is seen (bounded).
    task automatic wait_valid(output int unsigned lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RD_W-1:0] r,
                          input logic [XLEN-1:0] exp_res, input int unsigned exp_lat);
        int unsigned lat;
        send(o, a, b, r);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_rd"}, 64'(rd_out), 64'(r));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned lat;
        logic        seen;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul",        3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        run_op("mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
        run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'd2,        5'd7,  32'hFFFF_FFFF, 33);
        run_op("mulh",       3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 33);
        run_op("div",        3'b100, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, 33);
        run_op("rem",        3'b110, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, 33);
        run_op("divu",       3'b101, 32'd100,       32'd7,        5'd11, 32'd14,        33);
        run_op("remu",       3'b111, 32'd100,       32'd7,        5'd12, 32'd2,         33);
        run_op("divu_zero",  3'b101, 32'd5,         32'd0,        5'd13, 32'hFFFF_FFFF, 1);
        run_op("remu_zero",  3'b111, 32'd5,         32'd0,        5'd14, 32'd5,         1);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);

        // Back-pressure in DONE, then a request offered during the handshake.
        send(3'b000, 32'd6, 32'd7, 5'd17);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_result", 64'(result), 64'd42);
            check("bp_rd", 64'(rd_out), 64'd17);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b000; src1 = 32'd1; src2 = 32'd1; rd_in = 5'd1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_release", {61'd0, in_ready, busy, out_valid}, 64'd4);

        // Flush at T+10 of a divide.
        send(3'b101, 32'd100, 32'd7, 5'd18);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {61'd0, in_ready, busy, out_valid}, 64'd4);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", {63'd0, seen}, 64'd0);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd19, 32'd12, 33);

        // Reset in the middle of a busy operation.
        send(3'b000, 32'd3, 32'd4, 5'd20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {61'd0, in_ready, busy, out_valid}, 64'd4);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_rd", 64'(rd_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_valid", {63'd0, seen}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
